// File: rtl/i2c_master.sv
// Single-register I2C initiator: START, device byte, 16-bit address, one 16-bit data word, STOP.
// SCL is push-pull; SDA is open-drain (sda drive 1 = released).
module i2c_master #(
    parameter int unsigned HALF = 125
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        start,
    input  logic        rnw,
    input  logic [6:0]  dev_id,
    input  logic [15:0] reg_addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        SCL,
    output logic        oSDA,
    input  logic        iSDA
);

    localparam int unsigned PW = $clog2(HALF);
    localparam logic [PW-1:0] PhLast = PW'(HALF - 1);
    localparam logic [PW-1:0] PhMid  = PW'(HALF / 2);

    typedef enum logic [3:0] {
        StIdle, StStart, StDev, StAckDev, StAddrHi, StAckHi, StAddrLo, StAckLo, StData, StStop
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          high_q, high_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic          rnw_q, rnw_d;
    logic [6:0]    dev_q, dev_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rx_q, rx_d;
    logic          nack_q, nack_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          ack_err_q, ack_err_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          scl_q, scl_d;
    logic          sda_q, sda_d;

    // Slot-entry scratch: next state, its bit count and the first bit index to drive
    state_e        ns;
    logic [4:0]    nc;
    logic [3:0]    idx;
    logic          enter;
    logic [7:0]    dev_byte;

    assign dev_byte = {dev_q, rnw_q};

    always_comb begin
        state_d   = state_q;
        high_d    = high_q;
        bit_cnt_d = bit_cnt_q;
        rnw_d     = rnw_q;
        dev_d     = dev_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        nack_d    = nack_q;
        rd_data_d = rd_data_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        scl_d     = scl_q;
        sda_d     = sda_q;
        phase_d   = (phase_q == PhLast) ? '0 : phase_q + 1'b1;
        ns        = state_q;
        nc        = 5'd0;
        idx       = 4'd0;
        enter     = 1'b0;

        case (state_q)
            StIdle: begin
                phase_d = '0;
                scl_d   = 1'b1;
                sda_d   = 1'b1;
                busy_d  = 1'b0;
                // A request landing in the done cycle is dropped
                if (start && !done_q) begin
                    rnw_d     = rnw;
                    dev_d     = dev_id;
                    addr_d    = reg_addr;
                    wdata_d   = wr_data;
                    nack_d    = 1'b0;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                    sda_d     = 1'b0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (phase_q == PhLast) begin
                    enter = 1'b1;
                    ns    = StDev;
                    nc    = 5'd8;
                end
            end
            StStop: begin
                if (phase_q == PhLast) begin
                    if (!high_q) begin
                        high_d = 1'b1;
                        scl_d  = 1'b1;
                    end else begin
                        state_d   = StIdle;
                        high_d    = 1'b0;
                        sda_d     = 1'b1;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        ack_err_d = nack_q;
                        if (rnw_q && !nack_q) rd_data_d = rx_q;
                    end
                end
            end
            default: begin
                if (high_q && phase_q == PhMid) begin
                    if (state_q == StAckDev || state_q == StAckHi || state_q == StAckLo) begin
                        nack_d = iSDA;
                    end
                    if (state_q == StData && rnw_q) rx_d = {rx_q[14:0], iSDA};
                end
                if (phase_q == PhLast) begin
                    if (!high_q) begin
                        high_d = 1'b1;
                        scl_d  = 1'b1;
                    end else if (bit_cnt_q > 5'd1) begin
                        enter = 1'b1;
                        ns    = state_q;
                        nc    = bit_cnt_q - 5'd1;
                    end else begin
                        enter = 1'b1;
                        case (state_q)
                            StDev:    begin ns = StAckDev; nc = 5'd1; end
                            StAckDev: begin ns = nack_q ? StStop : StAddrHi; nc = 5'd8; end
                            StAddrHi: begin ns = StAckHi; nc = 5'd1; end
                            StAckHi:  begin ns = nack_q ? StStop : StAddrLo; nc = 5'd8; end
                            StAddrLo: begin ns = StAckLo; nc = 5'd1; end
                            StAckLo:  begin ns = nack_q ? StStop : StData; nc = 5'd16; end
                            default:  begin ns = StStop; nc = 5'd0; end
                        endcase
                    end
                end
            end
        endcase

        // New slot (or STOP) begins with SCL low; SDA changes only here while SCL falls
        if (enter) begin
            state_d   = ns;
            high_d    = 1'b0;
            scl_d     = 1'b0;
            phase_d   = '0;
            idx       = nc[3:0] - 4'd1;
            bit_cnt_d = (ns == StStop) ? 5'd0 : nc;
            case (ns)
                StDev:    sda_d = dev_byte[idx[2:0]];
                StAddrHi: sda_d = addr_q[{1'b1, idx[2:0]}];
                StAddrLo: sda_d = addr_q[{1'b0, idx[2:0]}];
                StData:   sda_d = rnw_q | wdata_q[idx];
                StStop:   sda_d = 1'b0;
                default:  sda_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            high_q    <= 1'b0;
            bit_cnt_q <= 5'd0;
            rnw_q     <= 1'b0;
            dev_q     <= 7'd0;
            addr_q    <= 16'd0;
            wdata_q   <= 16'd0;
            rx_q      <= 16'd0;
            nack_q    <= 1'b0;
            rd_data_q <= 16'd0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            high_q    <= high_d;
            bit_cnt_q <= bit_cnt_d;
            rnw_q     <= rnw_d;
            dev_q     <= dev_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rx_q      <= rx_d;
            nack_q    <= nack_d;
            rd_data_q <= rd_data_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign SCL     = scl_q;
    assign oSDA    = sda_q;

endmodule
